// File: rtl/isp_track_pkg.sv
// Shared definitions for the colour-class tracker: window layout, class lookup,
// publish FSM states and defaults.
package isp_track_pkg;

    localparam int TH_W      = 48;
    localparam int Y_TH_OFS  = 40;
    localparam int Y_TL_OFS  = 32;
    localparam int CB_TH_OFS = 24;
    localparam int CB_TL_OFS = 16;
    localparam int CR_TH_OFS = 8;
    localparam int CR_TL_OFS = 0;

    // Upper bound on N_CLASS; the config bus is zero-extended to this many windows.
    localparam int MAX_CLASS   = 16;
    localparam int DEF_MIN_PIX = 64;

    typedef enum logic [1:0] {
        IDLE_FRAME,
        ACCUM,
        PUBLISH
    } trk_state_t;

    function automatic logic [TH_W-1:0] class_window(
        input logic [MAX_CLASS*TH_W-1:0] cfg,
        input int                        k
    );
        if (k < 0 || k >= MAX_CLASS) return '0;
        return cfg[k*TH_W +: TH_W];
    endfunction

endpackage

// File: rtl/ycbcr_window_match.sv
// Combinational inclusive compare of one {Y,Cb,Cr} pixel against one
// {Y_TH,Y_TL,CB_TH,CB_TL,CR_TH,CR_TL} window; TL > TH simply never matches.
module ycbcr_window_match
    import isp_track_pkg::*;
(
    input  logic [23:0]     ycbcr,
    input  logic [TH_W-1:0] window,
    output logic            hit
);

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign hit = in_range(ycbcr[23:16], window[Y_TL_OFS +: 8],  window[Y_TH_OFS +: 8])  &&
                 in_range(ycbcr[15:8],  window[CB_TL_OFS +: 8], window[CB_TH_OFS +: 8]) &&
                 in_range(ycbcr[7:0],   window[CR_TL_OFS +: 8], window[CR_TH_OFS +: 8]);

endmodule

// File: rtl/ycbcr_multi_tracker.sv
// N-class YCbCr tracker: per-frame bounding box, centre and found flag for the
// class selected at the last frame boundary. Optional macro TRACK_HOLD_EN holds the last found box.
module ycbcr_multi_tracker
    import isp_track_pkg::*;
#(
    parameter int N_CLASS   = 4,
    parameter int SEL_W     = 2,
    parameter int CW        = 12,
    parameter int MIN_PIX   = DEF_MIN_PIX,
    parameter bit VS_ACTIVE = 1'b1
) (
    input  logic                    pixelclk,
    input  logic                    rstin,
    input  logic [23:0]             i_ycbcr,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    input  logic                    i_de,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [TH_W*N_CLASS-1:0] i_th_cfg,
    output logic [CW-1:0]           o_hcount_l,
    output logic [CW-1:0]           o_hcount_r,
    output logic [CW-1:0]           o_vcount_l,
    output logic [CW-1:0]           o_vcount_r,
    output logic [CW-1:0]           o_hcenter,
    output logic [CW-1:0]           o_vcenter,
    output logic                    o_found,
    output logic                    o_box_valid,
    output logic [SEL_W-1:0]        o_active_sel
);

    localparam logic [2*CW-1:0] MIN_PIX_C = (2*CW)'(MIN_PIX);

    logic                  hsync_unused;
    logic                  de_g, de_r, vs_r, vs_rr, frame_evt;
    logic [CW-1:0]         hcnt, vcnt, hcnt_r, vcnt_r;
    logic [23:0]           ycbcr_r;
    logic [SEL_W-1:0]      sel_cur;
    logic [MAX_CLASS*TH_W-1:0] cfg_ext;
    logic                  match, hit, keep_box, found_nxt;
    logic [CW-1:0]         hmin, hmax, vmin, vmax;
    logic [2*CW-1:0]       pix_cnt;
    logic [CW:0]           hsum, vsum;
    trk_state_t            state, state_nxt;

    assign hsync_unused = i_hsync;
    assign de_g         = i_de && (i_vsync != VS_ACTIVE);
    assign frame_evt    = (vs_r == VS_ACTIVE) && (vs_rr != VS_ACTIVE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (de_g) begin
                if (hcnt != '1) hcnt <= hcnt + CW'(1);
            end else if (de_r) begin
                hcnt <= '0;
            end
            if (frame_evt)                             vcnt <= '0;
            else if (de_r && !de_g && (vcnt != '1))    vcnt <= vcnt + CW'(1);
        end
    end

    // Sync history resets to the blanking level so a release mid-blank is not seen as a frame edge.
    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            ycbcr_r <= '0;
            de_r    <= 1'b0;
            hcnt_r  <= '0;
            vcnt_r  <= '0;
            vs_r    <= VS_ACTIVE;
            vs_rr   <= VS_ACTIVE;
        end else begin
            ycbcr_r <= i_ycbcr;
            de_r    <= de_g;
            hcnt_r  <= hcnt;
            vcnt_r  <= vcnt;
            vs_r    <= i_vsync;
            vs_rr   <= vs_r;
        end
    end

    always_comb begin
        cfg_ext = '0;
        cfg_ext[N_CLASS*TH_W-1:0] = i_th_cfg;
    end

    ycbcr_window_match u_match (
        .ycbcr  (ycbcr_r),
        .window (class_window(cfg_ext, int'(sel_cur))),
        .hit    (match)
    );

    assign hit = de_r && match && (int'(sel_cur) < N_CLASS);

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            hmin    <= '1;
            hmax    <= '0;
            vmin    <= '1;
            vmax    <= '0;
            pix_cnt <= '0;
        end else if (frame_evt) begin
            hmin    <= '1;
            hmax    <= '0;
            vmin    <= '1;
            vmax    <= '0;
            pix_cnt <= '0;
        end else if (hit) begin
            if ((pix_cnt == '0) || (hcnt_r < hmin)) hmin <= hcnt_r;
            if ((pix_cnt == '0) || (hcnt_r > hmax)) hmax <= hcnt_r;
            if ((pix_cnt == '0) || (vcnt_r < vmin)) vmin <= vcnt_r;
            if ((pix_cnt == '0) || (vcnt_r > vmax)) vmax <= vcnt_r;
            if (pix_cnt != '1) pix_cnt <= pix_cnt + (2*CW)'(1);
        end
    end

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) state <= IDLE_FRAME;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_FRAME, ACCUM: if (frame_evt) state_nxt = PUBLISH;
            PUBLISH:           state_nxt = frame_evt ? PUBLISH : ACCUM;
            default:           state_nxt = IDLE_FRAME;
        endcase
    end

    assign o_box_valid = (state == PUBLISH);

`ifdef TRACK_HOLD_EN
    assign keep_box = 1'b1;
`else
    assign keep_box = 1'b0;
`endif

    assign found_nxt = (pix_cnt >= MIN_PIX_C);
    assign hsum      = {1'b0, hmin} + {1'b0, hmax};
    assign vsum      = {1'b0, vmin} + {1'b0, vmax};

    always_ff @(posedge pixelclk or negedge rstin) begin
        if (!rstin) begin
            o_hcount_l   <= '0;
            o_hcount_r   <= '0;
            o_vcount_l   <= '0;
            o_vcount_r   <= '0;
            o_hcenter    <= '0;
            o_vcenter    <= '0;
            o_found      <= 1'b0;
            o_active_sel <= '0;
            sel_cur      <= '0;
        end else if (frame_evt) begin
            o_found      <= found_nxt;
            o_active_sel <= sel_cur;
            sel_cur      <= i_sel;
            if (found_nxt) begin
                o_hcount_l <= hmin;
                o_hcount_r <= hmax;
                o_vcount_l <= vmin;
                o_vcount_r <= vmax;
                o_hcenter  <= hsum[CW:1];
                o_vcenter  <= vsum[CW:1];
            end else if (!keep_box) begin
                o_hcount_l <= '0;
                o_hcount_r <= '0;
                o_vcount_l <= '0;
                o_vcount_r <= '0;
                o_hcenter  <= '0;
                o_vcenter  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_multi_tracker.sv
// Scoreboard bench for ycbcr_multi_tracker: a pixel-level reference model pushes the
// expected per-frame result; a monitor pops it on each o_box_valid pulse.
module tb_ycbcr_multi_tracker;

    localparam int N_CLASS = 3;
    localparam int SEL_W   = 2;
    localparam int CW      = 7;
    localparam int MIN_PIX = 64;
    localparam int CMAX    = (1 << CW) - 1;
    localparam int PMAX    = (1 << (2*CW)) - 1;

    typedef struct packed {
        logic [CW-1:0]    l, r, t, b, hc, vc;
        logic             found;
        logic [SEL_W-1:0] sel;
    } box_t;

    logic                    pixelclk = 1'b0;
    logic                    rstin    = 1'b0;
    logic [23:0]             i_ycbcr  = '0;
    logic                    i_hsync  = 1'b0;
    logic                    i_vsync  = 1'b0;
    logic                    i_de     = 1'b0;
    logic [SEL_W-1:0]        i_sel    = '0;
    logic [48*N_CLASS-1:0]   i_th_cfg = '0;
    logic [CW-1:0]           o_hcount_l, o_hcount_r, o_vcount_l, o_vcount_r, o_hcenter, o_vcenter;
    logic                    o_found, o_box_valid;
    logic [SEL_W-1:0]        o_active_sel;

    always #5 pixelclk = ~pixelclk;

    ycbcr_multi_tracker #(
        .N_CLASS(N_CLASS), .SEL_W(SEL_W), .CW(CW), .MIN_PIX(MIN_PIX), .VS_ACTIVE(1'b1)
    ) dut (
        .pixelclk(pixelclk), .rstin(rstin), .i_ycbcr(i_ycbcr), .i_hsync(i_hsync),
        .i_vsync(i_vsync), .i_de(i_de), .i_sel(i_sel), .i_th_cfg(i_th_cfg),
        .o_hcount_l(o_hcount_l), .o_hcount_r(o_hcount_r),
        .o_vcount_l(o_vcount_l), .o_vcount_r(o_vcount_r),
        .o_hcenter(o_hcenter), .o_vcenter(o_vcenter), .o_found(o_found),
        .o_box_valid(o_box_valid), .o_active_sel(o_active_sel)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    box_t exp_q[$];
    box_t cur_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per publish pulse, otherwise outputs must hold.
    initial begin
        box_t act;
        cur_exp = '0;
        forever begin
            @(negedge pixelclk);
            act = '{l: o_hcount_l, r: o_hcount_r, t: o_vcount_l, b: o_vcount_r,
                    hc: o_hcenter, vc: o_vcenter, found: o_found, sel: o_active_sel};
            if (!rstin) begin
                cur_exp = '0;
                check("reset_outputs", 64'({act, o_box_valid}), 64'(0));
            end else if (o_box_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_publish", 64'(1), 64'(0));
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("publish_box", 64'({act.l, act.r, act.t, act.b, act.hc, act.vc}),
                          64'({cur_exp.l, cur_exp.r, cur_exp.t, cur_exp.b, cur_exp.hc, cur_exp.vc}));
                    check("publish_found", 64'(act.found), 64'(cur_exp.found));
                    check("publish_sel", 64'(act.sel), 64'(cur_exp.sel));
                end
            end else begin
                check("outputs_stable", 64'(act), 64'(cur_exp));
            end
        end
    end

    // ---------------- reference model ----------------
    int   lo [N_CLASS][3];
    int   hi [N_CLASS][3];
    int   m_cnt, m_l, m_r, m_t, m_b, m_row, frame_class;
    box_t held;

    int          r1x, r1y, r1w, r1h, r2x, r2y, r2w, r2h;
    logic [23:0] c1, c2, bg_col;
    bit          bg_rand;

    function automatic bit in_class(input int k, input logic [23:0] c);
        int v;
        if (k >= N_CLASS) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = int'(c[23-8*i -: 8]);
            if (v < lo[k][i] || v > hi[k][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] rand_in(input int k);
        logic [23:0] c;
        for (int i = 0; i < 3; i++)
            c[23-8*i -: 8] = (lo[k][i] <= hi[k][i]) ? 8'($urandom_range(hi[k][i], lo[k][i]))
                                                    : 8'($urandom_range(0, 255));
        return c;
    endfunction

    function automatic logic [23:0] colour_at(input int x, input int y);
        if (x >= r1x && x < r1x + r1w && y >= r1y && y < r1y + r1h) return c1;
        if (x >= r2x && x < r2x + r2w && y >= r2y && y < r2y + r2h) return c2;
        if (bg_rand) return 24'($urandom);
        return bg_col;
    endfunction

    task automatic apply_cfg();
        for (int k = 0; k < N_CLASS; k++)
            i_th_cfg[48*k +: 48] = {8'(hi[k][0]), 8'(lo[k][0]), 8'(hi[k][1]),
                                    8'(lo[k][1]), 8'(hi[k][2]), 8'(lo[k][2])};
    endtask

    task automatic model_clear();
        m_cnt = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0;
    endtask

    task automatic model_hit(input int x, input int y);
        int xs, ys;
        xs = (x > CMAX) ? CMAX : x;
        ys = (y > CMAX) ? CMAX : y;
        if (m_cnt == 0) begin
            m_l = xs; m_r = xs; m_t = ys; m_b = ys;
        end else begin
            if (xs < m_l) m_l = xs;
            if (xs > m_r) m_r = xs;
            if (ys < m_t) m_t = ys;
            if (ys > m_b) m_b = ys;
        end
        if (m_cnt < PMAX) m_cnt++;
    endtask

    task automatic drive(input bit de, input bit vs, input logic [23:0] c);
        i_de    = de;
        i_vsync = vs;
        i_ycbcr = c;
        i_hsync = !de;
        @(posedge pixelclk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rstin = 1'b0;
        model_clear();
        frame_class = 0;
        held        = '0;
        m_row       = 0;
        repeat (cycles) drive(1'b0, 1'b0, 24'h0);
        rstin = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 24'h0);
    endtask

    task automatic frame(input int w, input int h, input int rst_row,
                         input int sw_row, input int new_sel);
        logic [23:0] c;
        for (int r = 0; r < h; r++) begin
            if (r == rst_row) do_reset(3);
            if (r == sw_row)  i_sel = new_sel[SEL_W-1:0];
            for (int x = 0; x < w; x++) begin
                c = colour_at(x, r);
                if (in_class(frame_class, c)) model_hit(x, m_row);
                drive(1'b1, 1'b0, c);
            end
            repeat (4) drive(1'b0, 1'b0, 24'h0);
            m_row++;
        end
    endtask

    // Frame boundary: the frame just ended is published, i_sel becomes the next class.
    task automatic vblank();
        box_t e;
        if (m_cnt >= MIN_PIX) begin
            e.l = m_l[CW-1:0]; e.r = m_r[CW-1:0];
            e.t = m_t[CW-1:0]; e.b = m_b[CW-1:0];
            e.hc = CW'((m_l + m_r) / 2);
            e.vc = CW'((m_t + m_b) / 2);
            e.found = 1'b1;
            held = e;
        end else begin
`ifdef TRACK_HOLD_EN
            e = held;
`else
            e = '0;
`endif
            e.found = 1'b0;
        end
        e.sel = frame_class[SEL_W-1:0];
        exp_q.push_back(e);
        frame_class = int'(i_sel);
        model_clear();
        m_row = 0;
        repeat (6) drive(1'($urandom), 1'b1, 24'($urandom));
        repeat (3) drive(1'b0, 1'b0, 24'h0);
    endtask

    task automatic set_class(input int k, input int ylo, input int yhi, input int cblo,
                             input int cbhi, input int crlo, input int crhi);
        lo[k][0] = ylo;  hi[k][0] = yhi;
        lo[k][1] = cblo; hi[k][1] = cbhi;
        lo[k][2] = crlo; hi[k][2] = crhi;
    endtask

    task automatic set_rects(input int ax, input int ay, input int aw, input int ah,
                             input int bx, input int by, input int bw, input int bh);
        r1x = ax; r1y = ay; r1w = aw; r1h = ah;
        r2x = bx; r2y = by; r2w = bw; r2h = bh;
    endtask

    initial begin
        int a, b;
        model_clear();
        m_row = 0; frame_class = 0; held = '0;
        bg_col = 24'h000000; bg_rand = 1'b0;
        set_rects(0, 0, 0, 0, 0, 0, 0, 0);
        c1 = '0; c2 = '0;

        repeat (3) @(posedge pixelclk);
        #1;
        rstin = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 24'h0);

        set_class(0, 16, 235, 77, 127, 133, 173);
        set_class(1, 200, 220, 10, 20, 10, 20);
        set_class(2, 50, 90, 150, 200, 20, 60);
        apply_cfg();
        i_sel = 2'd0;
        vblank();                                  // empty partial frame after reset

        c1 = {8'd128, 8'd100, 8'd150};             // class 0 colour
        c2 = {8'd70, 8'd175, 8'd40};               // class 2 colour

        set_rects(10, 12, 20, 10, 0, 0, 0, 0);     // 200 pixels -> found
        frame(64, 40, -1, -1, 0);
        vblank();

        set_rects(30, 5, 5, 5, 0, 0, 0, 0);        // 25 pixels -> not found
        frame(64, 40, -1, -1, 0);
        vblank();

        set_rects(5, 5, 12, 8, 30, 20, 10, 10);    // class switch mid-frame
        frame(64, 40, -1, 20, 2);
        vblank();
        frame(64, 40, -1, -1, 0);
        i_sel = 2'd3;                              // out-of-range class next
        vblank();
        frame(64, 40, -1, -1, 0);
        i_sel = 2'd0;
        vblank();

        set_rects(5, 10, 12, 20, 0, 0, 0, 0);      // reset between rows mid-frame
        frame(64, 40, 20, -1, 0);
        vblank();

        set_rects(120, 120, 8, 8, 0, 0, 0, 0);     // exactly MIN_PIX at the max corner
        frame(128, 128, -1, -1, 0);
        vblank();

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N_CLASS; k++)
                for (int i = 0; i < 3; i++) begin
                    a = int'($urandom_range(0, 220));
                    b = a + int'($urandom_range(0, 35));
                    if ($urandom_range(0, 9) == 0) begin
                        lo[k][i] = b; hi[k][i] = a;
                    end else begin
                        lo[k][i] = a; hi[k][i] = b;
                    end
                end
            apply_cfg();
            set_rects(int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
                      int'($urandom_range(2, 16)), int'($urandom_range(2, 12)),
                      int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
                      int'($urandom_range(2, 16)), int'($urandom_range(2, 12)));
            c1 = rand_in(int'($urandom_range(0, N_CLASS - 1)));
            c2 = rand_in(int'($urandom_range(0, N_CLASS - 1)));
            bg_rand = 1'($urandom);
            frame(int'($urandom_range(16, 48)), int'($urandom_range(8, 32)), -1,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            vblank();
        end

        frame(32, 6, -1, -1, 0);                   // no vsync edge: nothing published
        repeat (20) drive(1'b0, 1'b0, 24'h0);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
